// File: rtl/lut_decoder.sv
`timescale 1ns/1ps
// Run-time programmable truth-table decoder: registered lookup of an input code,
// per-entry defined flag, valid/ready output stage and a saturating miss counter.
module lut_decoder #(
   parameter int               IN_W      = 3,
   parameter int               OUT_W     = 2,
   parameter logic [OUT_W-1:0] UNDEF_VAL = '0,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [IN_W-1:0]  cfg_addr,
   input  logic [OUT_W-1:0] cfg_data,
   input  logic             cfg_def,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_def,
   output logic [CNT_W-1:0] miss_cnt,
   input  logic             miss_clr
);
   localparam int               DEPTH   = 2**IN_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DEPTH-1:0] tbl_def;
   logic [OUT_W-1:0] tbl_data [DEPTH];

   // Table lives in flops: every entry must read as undefined straight out of reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         localparam logic [IN_W-1:0] ADDR = IN_W'(gi);
         logic             def_q;
         logic [OUT_W-1:0] data_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               def_q  <= 1'b0;
               data_q <= '0;
            end else if (cfg_we && (cfg_addr == ADDR)) begin
               def_q  <= cfg_def;
               data_q <= cfg_data;
            end
         end

         assign tbl_def[gi]  = def_q;
         assign tbl_data[gi] = data_q;
      end
   endgenerate

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q,  out_data_d;
   logic             out_def_q,   out_def_d;
   logic [CNT_W-1:0] miss_cnt_q,  miss_cnt_d;
   logic             accept;
   logic             entry_def;
   logic [OUT_W-1:0] entry_data;

   assign in_ready   = !out_valid_q || out_ready;
   assign accept     = in_valid && in_ready;
   // Reads the pre-write entry, so a same-cycle cfg write only affects later lookups.
   assign entry_def  = tbl_def[in_code];
   assign entry_data = tbl_data[in_code];

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_def_d   = out_def_q;
      miss_cnt_d  = miss_cnt_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_def_d   = entry_def;
         out_data_d  = entry_def ? entry_data : UNDEF_VAL;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (miss_clr) begin
         miss_cnt_d = '0;
      end else if (accept && !entry_def && (miss_cnt_q != CNT_MAX)) begin
         miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= UNDEF_VAL;
         out_def_q   <= 1'b0;
         miss_cnt_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_def_q   <= out_def_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_def   = out_def_q;
   assign miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_lut_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench for lut_decoder: a stimulus process predicts each accepted lookup,
// a separate monitor checks every presented output against the expected queue.
module tb_lut_decoder;
   localparam int         IN_W  = 3;
   localparam int         OUT_W = 2;
   localparam int         CNT_W = 8;
   localparam logic [1:0] UNDEF = 2'b00;

   logic             clk;
   logic             rst_n;
   logic             cfg_we;
   logic [IN_W-1:0]  cfg_addr;
   logic [OUT_W-1:0] cfg_data;
   logic             cfg_def;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_code;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_def;
   logic [CNT_W-1:0] miss_cnt;
   logic             miss_clr;

   // Narrow-counter copy sharing all inputs, used only for its saturating miss_cnt.
   logic             in_ready2;
   logic             out_valid2;
   logic [OUT_W-1:0] out_data2;
   logic             out_def2;
   logic [1:0]       miss_cnt2;

   lut_decoder #(.IN_W(IN_W), .OUT_W(OUT_W), .UNDEF_VAL(UNDEF), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_def(cfg_def),
      .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_def(out_def),
      .miss_cnt(miss_cnt), .miss_clr(miss_clr)
   );

   lut_decoder #(.IN_W(IN_W), .OUT_W(OUT_W), .UNDEF_VAL(UNDEF), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_def(cfg_def),
      .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_def(out_def2),
      .miss_cnt(miss_cnt2), .miss_clr(miss_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] data;
      logic       def;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] m_data[8];
   logic       m_def[8];
   logic       m_ov;
   int         m_cnt;
   int         m_cnt2;
   int         errors = 0;
   int         checks = 0;
   int         n_acc  = 0;
   int         n_out  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_data[i] = 2'b00;
         m_def[i]  = 1'b0;
      end
      m_ov   = 1'b0;
      m_cnt  = 0;
      m_cnt2 = 0;
      sb.delete();
   endtask

   // One clock of stimulus: drive at negedge, check registered state, then predict the edge.
   task automatic cycle(input logic we, input int addr, input logic [1:0] data, input logic def,
                        input logic iv, input int code, input logic ordy, input logic clr);
      logic acc;
      exp_t e;
      @(negedge clk);
      cfg_we    = we;
      cfg_addr  = addr[2:0];
      cfg_data  = data;
      cfg_def   = def;
      in_valid  = iv;
      in_code   = code[2:0];
      out_ready = ordy;
      miss_clr  = clr;
      #2;
      check("out_valid", out_valid, m_ov);
      check("in_ready", in_ready, !m_ov || ordy);
      check("miss_cnt", miss_cnt, m_cnt);
      check("miss_cnt_w2", miss_cnt2, m_cnt2);
      acc = iv && (!m_ov || ordy);
      if (acc) begin
         e.def  = m_def[code];
         e.data = e.def ? m_data[code] : UNDEF;
         sb.push_back(e);
         n_acc++;
         $display("accept code=%0d expect data=%b def=%0d", code, e.data, e.def);
         if (!e.def) begin
            m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
            m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
         end
      end
      if (clr) begin
         m_cnt  = 0;
         m_cnt2 = 0;
      end
      if (acc) m_ov = 1'b1;
      else if (ordy) m_ov = 1'b0;
      if (we) begin
         m_def[addr]  = def;
         m_data[addr] = data;
      end
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 0, 2'b00, 1'b0, 1'b0, 0, ordy, 1'b0);
   endtask

   task automatic lookup(input int code, input logic ordy);
      cycle(1'b0, 0, 2'b00, 1'b0, 1'b1, code, ordy, 1'b0);
   endtask

   task automatic reset_mid();
      @(negedge clk);
      rst_n     = 1'b0;
      cfg_we    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      miss_clr  = 1'b0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, UNDEF);
      check("rst_out_def", out_def, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      check("rst_miss_cnt_w2", miss_cnt2, 0);
      $display("reset applied, %0d pending results discarded", sb.size());
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every presented output must equal the head of the queue; pop on handshake.
   always @(negedge clk) begin
      #1;
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            check("spurious_out_valid", 1, 0);
         end else begin
            check("out_data", out_data, sb[0].data);
            check("out_def", out_def, sb[0].def);
            if (out_ready) begin
               $display("result data=%b def=%0d", out_data, out_def);
               void'(sb.pop_front());
               n_out++;
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      cfg_def   = 1'b0;
      in_valid  = 1'b0;
      in_code   = '0;
      out_ready = 1'b0;
      miss_clr  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #2;
      check("init_out_valid", out_valid, 0);
      check("init_out_data", out_data, UNDEF);
      check("init_out_def", out_def, 0);
      check("init_miss_cnt", miss_cnt, 0);
      check("init_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Program three entries, then stream 7,6,4,0 back-to-back.
      cycle(1'b1, 7, 2'b01, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      cycle(1'b1, 6, 2'b11, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      cycle(1'b1, 4, 2'b00, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      lookup(7, 1'b1);
      lookup(6, 1'b1);
      lookup(4, 1'b1);
      lookup(0, 1'b1);
      idle(1'b1);
      idle(1'b1);
      check("stream_miss_cnt", miss_cnt, 1);

      // Backpressure: consumer stalls for three cycles while the source keeps offering.
      lookup(6, 1'b0);
      lookup(7, 1'b0);
      lookup(7, 1'b0);
      lookup(7, 1'b0);
      lookup(7, 1'b1);
      lookup(4, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Same-cycle write and lookup of entry 5, then a repeat lookup.
      cycle(1'b1, 5, 2'b10, 1'b1, 1'b1, 5, 1'b1, 1'b0);
      lookup(5, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Saturation on the 2-bit counter and clear-over-increment.
      cycle(1'b0, 0, 2'b00, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) lookup(3, 1'b1);
      idle(1'b1);
      check("sat_miss_cnt_w2", miss_cnt2, 3);
      cycle(1'b0, 0, 2'b00, 1'b0, 1'b1, 3, 1'b1, 1'b1);
      idle(1'b1);
      check("clr_miss_cnt_w2", miss_cnt2, 0);

      // Random traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), 2'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
               $urandom_range(0, 19) == 0);
      end

      // Reset with a result held under backpressure; table must read undefined afterwards.
      lookup(2, 1'b0);
      lookup(1, 1'b0);
      reset_mid();
      for (int c = 0; c < 8; c++) lookup(c, 1'b1);

      for (int i = 0; i < 4; i++) idle(1'b1);
      check("drain_queue_empty", sb.size(), 0);
      check("final_miss_cnt", miss_cnt, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
